// File: rtl/cell_test_pkg.sv
// Shared types and sizes for the standard-cell sweep controller.
package cell_test_pkg;

  localparam int unsigned SOURCE_W  = 3;
  localparam int unsigned TARGET_W  = 8;
  localparam int unsigned NUM_CODES = 8;

  typedef enum logic [2:0] {
    StIdle,
    StApply,
    StSettle,
    StSample,
    StFinish
  } sweep_state_t;

endpackage

// File: rtl/cell_sweep_controller_if.sv
// Host/cell-side signal bundle of the sweep controller; slave is the controller's view.
interface cell_sweep_controller_if #(
  parameter int unsigned SETTLE_W = 4
);
  import cell_test_pkg::*;

  logic                start;
  logic                abort;
  logic [SETTLE_W-1:0] settle;
  logic [TARGET_W-1:0] care_mask;
  logic [SOURCE_W-1:0] exp_idx;
  logic [TARGET_W-1:0] exp_val;
  logic [TARGET_W-1:0] target;
  logic [SOURCE_W-1:0] source;
  logic                busy;
  logic                done;
  logic                valid;
  logic                pass;
  logic [TARGET_W-1:0] fail_mask;
  logic [SOURCE_W-1:0] first_fail;
  logic [TARGET_W-1:0] last_target;

  modport master (
    output start, abort, settle, care_mask, exp_val, target,
    input  exp_idx, source, busy, done, valid, pass, fail_mask, first_fail, last_target
  );

  modport slave (
    input  start, abort, settle, care_mask, exp_val, target,
    output exp_idx, source, busy, done, valid, pass, fail_mask, first_fail, last_target
  );

endinterface

// File: rtl/settle_counter.sv
// Down-counter timing the per-code settle window; expire flags the final settle cycle.
module settle_counter #(
  parameter int unsigned SETTLE_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                dec,
  input  logic [SETTLE_W-1:0] load_val,
  output logic                expire
);

  logic [SETTLE_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == SETTLE_W'(1));

endmodule

// File: rtl/cell_sweep_controller.sv
// Steps the cell input through all codes, waits a settle time, and compares the
// masked response against the expected lookup, accumulating a per-code fail mask.
module cell_sweep_controller
  import cell_test_pkg::*;
#(
  parameter int unsigned SETTLE_W = 4
) (
  input logic                     clk,
  input logic                     rst,
  cell_sweep_controller_if.slave  bus
);

  sweep_state_t        state_d, state_q;
  logic [SETTLE_W-1:0] settle_d, settle_q;
  logic [TARGET_W-1:0] care_d, care_q;
  logic [SOURCE_W-1:0] source_d, source_q;
  logic [TARGET_W-1:0] fail_mask_d, fail_mask_q;
  logic [SOURCE_W-1:0] first_fail_d, first_fail_q;
  logic                valid_d, valid_q;
  logic [TARGET_W-1:0] last_target_d, last_target_q;
  logic                cnt_expire;
  logic                mismatch;

  settle_counter #(
    .SETTLE_W (SETTLE_W)
  ) u_settle_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (state_q == StApply),
    .dec      (state_q == StSettle),
    .load_val (settle_q),
    .expire   (cnt_expire)
  );

  assign mismatch = |((bus.target ^ bus.exp_val) & care_q);

  always_comb begin
    state_d       = state_q;
    settle_d      = settle_q;
    care_d        = care_q;
    source_d      = source_q;
    fail_mask_d   = fail_mask_q;
    first_fail_d  = first_fail_q;
    valid_d       = valid_q;
    last_target_d = last_target_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d      = StApply;
          settle_d     = bus.settle;
          care_d       = bus.care_mask;
          source_d     = '0;
          fail_mask_d  = '0;
          first_fail_d = '0;
          valid_d      = 1'b0;
        end
      end
      StApply: begin
        state_d = (settle_q != '0) ? StSettle : StSample;
      end
      StSettle: begin
        if (cnt_expire) begin
          state_d = StSample;
        end
      end
      StSample: begin
        last_target_d = bus.target;
        if (mismatch) begin
          fail_mask_d[source_q] = 1'b1;
          // Mask was cleared at start, so an empty mask means no earlier failure.
          if (fail_mask_q == '0) begin
            first_fail_d = source_q;
          end
        end
        if (source_q == SOURCE_W'(NUM_CODES - 1)) begin
          state_d  = StFinish;
          source_d = '0;
          valid_d  = 1'b1;
        end else begin
          state_d  = StApply;
          source_d = source_q + 1'b1;
        end
      end
      StFinish: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Abort outranks everything once a sweep is running; partial fail mask is kept.
    if (bus.abort && (state_q != StIdle)) begin
      state_d  = StIdle;
      source_d = '0;
      valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      settle_q      <= '0;
      care_q        <= '0;
      source_q      <= '0;
      fail_mask_q   <= '0;
      first_fail_q  <= '0;
      valid_q       <= 1'b0;
      last_target_q <= '0;
    end else begin
      state_q       <= state_d;
      settle_q      <= settle_d;
      care_q        <= care_d;
      source_q      <= source_d;
      fail_mask_q   <= fail_mask_d;
      first_fail_q  <= first_fail_d;
      valid_q       <= valid_d;
      last_target_q <= last_target_d;
    end
  end

  assign bus.source      = source_q;
  assign bus.exp_idx     = source_q;
  assign bus.busy        = (state_q == StApply) || (state_q == StSettle) ||
                           (state_q == StSample);
  assign bus.done        = (state_q == StFinish);
  assign bus.valid       = valid_q;
  assign bus.pass        = valid_q && (fail_mask_q == '0);
  assign bus.fail_mask   = fail_mask_q;
  assign bus.first_fail  = first_fail_q;
  assign bus.last_target = last_target_q;

endmodule

// File: tb/tb_cell_sweep_controller.sv
// Directed bench for cell_sweep_controller: vector table of sweeps plus abort/reset/restart cases.
module tb_cell_sweep_controller;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  logic [7:0] flip_codes;
  logic [7:0] flip_bits;

  cell_sweep_controller_if #(.SETTLE_W(4)) bus ();

  cell_sweep_controller #(
    .SETTLE_W (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0] settle;
    logic [7:0] care;
    logic [7:0] flip_codes;
    logic [7:0] flip_bits;
    int         exp_done;
    logic [7:0] exp_fm;
    logic [2:0] exp_ff;
    logic       exp_pass;
  } vec_t;

  vec_t vecs[6];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fault-free model of the cell under test.
  function automatic logic [7:0] cell_fn(input logic [2:0] c);
    return {c, ~c, c[0], c[2]};
  endfunction

  always_comb begin
    bus.exp_val = cell_fn(bus.exp_idx);
    bus.target  = cell_fn(bus.source) ^ (flip_codes[bus.source] ? flip_bits : 8'h00);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Start a sweep and observe it until a few cycles past done (or a timeout).
  task automatic run_sweep(input int restart_at, output int done_cyc, output int done_cnt,
                           output bit busy_ok, output bit seq_ok);
    logic [2:0] prev;
    done_cyc = -1;
    done_cnt = 0;
    busy_ok  = 1'b1;
    seq_ok   = 1'b1;
    prev     = 3'd0;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      bus.start = (cyc == restart_at);
      if (bus.done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc < 0) begin
        if (!bus.busy) busy_ok = 1'b0;
        if (bus.source != prev) begin
          if (int'(bus.source) != int'(prev) + 1) seq_ok = 1'b0;
          prev = bus.source;
        end
      end else if (bus.busy) begin
        busy_ok = 1'b0;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 4) break;
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
    if (prev != 3'd7) seq_ok = 1'b0;
  endtask

  task automatic check_idle_quiet(input string name, input int cycles);
    bit quiet;
    quiet = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) quiet = 1'b0;
    end
    check(name, 32'(quiet), 32'd1);
  endtask

  initial begin
    int         dc, dn;
    bit         bok, sok;
    logic [7:0] lt_exp;

    n_checks = 0;
    n_fail   = 0;

    vecs[0] = '{4'd0,  8'hFF, 8'h00, 8'h00, 17,  8'h00, 3'd0, 1'b1};
    vecs[1] = '{4'd3,  8'hFF, 8'h20, 8'h04, 41,  8'h20, 3'd5, 1'b0};
    vecs[2] = '{4'd3,  8'hFB, 8'h20, 8'h04, 41,  8'h00, 3'd0, 1'b1};
    vecs[3] = '{4'd1,  8'hFF, 8'h42, 8'h80, 25,  8'h42, 3'd1, 1'b0};
    vecs[4] = '{4'd15, 8'hFF, 8'h80, 8'h01, 137, 8'h80, 3'd7, 1'b0};
    vecs[5] = '{4'd2,  8'h01, 8'h01, 8'hFF, 33,  8'h01, 3'd0, 1'b0};

    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.settle    = '0;
    bus.care_mask = 8'hFF;
    flip_codes    = 8'h00;
    flip_bits     = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 32'({bus.source, bus.busy, bus.done, bus.valid, bus.pass,
                                bus.fail_mask, bus.first_fail, bus.last_target}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 6; v++) begin
      @(negedge clk);
      bus.settle    = vecs[v].settle;
      bus.care_mask = vecs[v].care;
      flip_codes    = vecs[v].flip_codes;
      flip_bits     = vecs[v].flip_bits;
      run_sweep(0, dc, dn, bok, sok);
      lt_exp = cell_fn(3'd7) ^ (vecs[v].flip_codes[7] ? vecs[v].flip_bits : 8'h00);
      check($sformatf("v%0d_done_cycle", v), 32'(dc), 32'(vecs[v].exp_done));
      check($sformatf("v%0d_done_count", v), 32'(dn), 32'd1);
      check($sformatf("v%0d_busy_window", v), 32'(bok), 32'd1);
      check($sformatf("v%0d_source_order", v), 32'(sok), 32'd1);
      check($sformatf("v%0d_fail_mask", v), 32'(bus.fail_mask), 32'(vecs[v].exp_fm));
      check($sformatf("v%0d_first_fail", v), 32'(bus.first_fail), 32'(vecs[v].exp_ff));
      check($sformatf("v%0d_pass", v), 32'(bus.pass), 32'(vecs[v].exp_pass));
      check($sformatf("v%0d_valid", v), 32'(bus.valid), 32'd1);
      check($sformatf("v%0d_last_target", v), 32'(bus.last_target), 32'(lt_exp));
    end

    // Start re-pulsed at cycle 5 of a running S=0 sweep is ignored.
    @(negedge clk);
    bus.settle    = 4'd0;
    bus.care_mask = 8'hFF;
    flip_codes    = 8'h00;
    run_sweep(5, dc, dn, bok, sok);
    check("restart_done_cycle", 32'(dc), 32'd17);
    check("restart_done_count", 32'(dn), 32'd1);
    check("restart_pass", 32'(bus.pass), 32'd1);

    // Abort during SETTLE of code 3 (S=3), with code 1 failing beforehand.
    @(negedge clk);
    bus.settle = 4'd3;
    flip_codes = 8'h02;
    flip_bits  = 8'h01;
    bus.start  = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int c = 2; c <= 18; c++) begin
      @(posedge clk);
      #1;
    end
    check("abort_pre_source", 32'(bus.source), 32'd3);
    check("abort_pre_busy", 32'(bus.busy), 32'd1);
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    check("abort_idle_outputs", 32'({bus.source, bus.busy, bus.valid, bus.done}), 32'd0);
    check("abort_partial_mask", 32'(bus.fail_mask), 32'h02);
    check_idle_quiet("abort_no_done", 30);
    @(negedge clk);
    bus.settle = 4'd0;
    flip_codes = 8'h00;
    run_sweep(0, dc, dn, bok, sok);
    check("post_abort_done_cycle", 32'(dc), 32'd17);
    check("post_abort_pass", 32'(bus.pass), 32'd1);

    // Start and abort together in IDLE: start wins.
    @(negedge clk);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("start_beats_abort", 32'(bus.busy), 32'd1);
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    check("abort_from_apply", 32'(bus.busy), 32'd0);

    // Asynchronous reset during SAMPLE of code 2 (S=2), with code 0 failing.
    @(negedge clk);
    bus.settle = 4'd2;
    flip_codes = 8'h01;
    flip_bits  = 8'h10;
    bus.start  = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int c = 2; c <= 12; c++) begin
      @(posedge clk);
      #1;
    end
    check("rst_pre_source", 32'(bus.source), 32'd2);
    check("rst_pre_fail_mask", 32'(bus.fail_mask), 32'h01);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_outputs", 32'({bus.source, bus.busy, bus.done, bus.valid, bus.pass,
                                    bus.fail_mask, bus.first_fail, bus.last_target}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check_idle_quiet("rst_no_done", 40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
